// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: 1-cycle lookup, registered mispredict/redirect.
// Stall holds prediction outputs only; table updates and mispredict generation continue.
module branch_predict_unit #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  input  logic        stall,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  input  logic        flush_table
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [1:0]         r_cnt [ENTRIES];
  logic [31:0]        r_tgt [ENTRIES];

  logic        r_pred_valid;
  logic        r_pred_taken;
  logic [31:0] r_pred_target;
  logic        r_mispredict;
  logic [31:0] r_redirect_pc;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_taken;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [1:0]       w_cnt_cur;
  logic [1:0]       w_cnt_nxt;
  logic             w_mispredict;
  logic             w_unused;

  assign w_lk_idx   = lookup_pc[IDX_W+1:2];
  assign w_lk_tag   = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_lk_taken = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag) && r_cnt[w_lk_idx][1];

  assign w_up_idx  = upd_pc[IDX_W+1:2];
  assign w_up_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_cnt_cur = r_cnt[w_up_idx];

  // Lookup PC bits outside index/tag carry no information for the prediction.
  assign w_unused = &{1'b0, lookup_pc[1:0], lookup_pc[31:IDX_W+TAG_W+2]};

  always_comb begin
    w_cnt_nxt = w_cnt_cur;
    if (upd_taken && (w_cnt_cur != 2'b11)) begin
      w_cnt_nxt = w_cnt_cur + 2'b01;
    end else if (!upd_taken && (w_cnt_cur != 2'b00)) begin
      w_cnt_nxt = w_cnt_cur - 2'b01;
    end
  end

  assign w_mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));

  // Table reads above use pre-edge state, so same-cycle lookups see the old entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i] <= '0;
        r_cnt[i] <= 2'b01;
        r_tgt[i] <= '0;
      end
    end else if (flush_table) begin
      r_valid <= '0;
    end else if (upd_valid) begin
      if (w_up_hit) begin
        r_cnt[w_up_idx] <= w_cnt_nxt;
        if (upd_taken) begin
          r_tgt[w_up_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_tag[w_up_idx]   <= w_up_tag;
        r_cnt[w_up_idx]   <= 2'b10;
        r_tgt[w_up_idx]   <= upd_target;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else if (!stall) begin
      r_pred_valid  <= lookup_valid;
      r_pred_taken  <= lookup_valid && w_lk_taken;
      r_pred_target <= (lookup_valid && w_lk_taken) ? r_tgt[w_lk_idx] : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_mispredict  <= w_mispredict;
      r_redirect_pc <= !w_mispredict ? 32'h0 :
                       upd_taken     ? upd_target : (upd_pc + 32'd8);
    end
  end

  assign pred_valid  = r_pred_valid;
  assign pred_taken  = r_pred_taken;
  assign pred_target = r_pred_target;
  assign mispredict  = r_mispredict;
  assign redirect_pc = r_redirect_pc;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed vector table for branch_predict_unit plus hand sequences for reset corners.
module tb_branch_predict_unit;
  logic        clk = 1'b0;
  logic        resetn;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        stall;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        flush_table;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_1010;
  localparam logic [31:0] PC = 32'h0040_0020;
  localparam logic [31:0] PD = 32'h0040_0040;
  localparam logic [31:0] TA = 32'h0040_0100;
  localparam logic [31:0] TC = 32'h0040_0300;

  branch_predict_unit #(.ENTRIES(64), .TAG_W(10)) dut (
    .clk(clk), .resetn(resetn),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .stall(stall),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .flush_table(flush_table)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        lk_vld;
    logic [31:0] lk_pc;
    logic        stl;
    logic        flush;
    logic        u_vld;
    logic [31:0] u_pc;
    logic        u_tk;
    logic [31:0] u_tgt;
    logic        u_ptk;
    logic [31:0] u_ptgt;
    logic        e_pv;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_red;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic lv, logic [31:0] lp, logic st, logic fl,
                              logic uv, logic [31:0] up, logic ut, logic [31:0] utg,
                              logic upt, logic [31:0] uptg,
                              logic pv, logic pt, logic [31:0] ptg, logic ms, logic [31:0] rd);
    vec_t v;
    v.name = nm; v.lk_vld = lv; v.lk_pc = lp; v.stl = st; v.flush = fl;
    v.u_vld = uv; v.u_pc = up; v.u_tk = ut; v.u_tgt = utg; v.u_ptk = upt; v.u_ptgt = uptg;
    v.e_pv = pv; v.e_pt = pt; v.e_ptgt = ptg; v.e_mis = ms; v.e_red = rd;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    lookup_valid = 0; lookup_pc = 0; stall = 0; flush_table = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    upd_pred_taken = 0; upd_pred_target = 0;
  endtask

  task automatic check_outs(string nm, logic pv, logic pt, logic [31:0] ptg,
                            logic ms, logic [31:0] rd);
    chk({nm, ".pred_valid"}, {31'b0, pred_valid}, {31'b0, pv});
    chk({nm, ".pred_taken"}, {31'b0, pred_taken}, {31'b0, pt});
    chk({nm, ".pred_target"}, pred_target, ptg);
    chk({nm, ".mispredict"}, {31'b0, mispredict}, {31'b0, ms});
    chk({nm, ".redirect_pc"}, redirect_pc, rd);
  endtask

  initial begin
    //               name        lv  lk_pc        st fl uv upd_pc        tk tgt           ptk ptgt            pv pt ptgt  mis red
    vecs.push_back(mk("cold",     1, PA,          0, 0, 0, 0,            0, 0,            0, 0,            1, 0, 0,  0, 0));
    vecs.push_back(mk("idle",     0, 0,           0, 0, 0, 0,            0, 0,            0, 0,            0, 0, 0,  0, 0));
    vecs.push_back(mk("alloc_A",  0, 0,           0, 0, 1, PA,           1, TA,           0, 0,            0, 0, 0,  1, TA));
    vecs.push_back(mk("hit_A",    1, PA,          0, 0, 0, 0,            0, 0,            0, 0,            1, 1, TA, 0, 0));
    vecs.push_back(mk("alias_B",  1, PB,          0, 0, 0, 0,            0, 0,            0, 0,            1, 0, 0,  0, 0));
    vecs.push_back(mk("nt1_A",    1, PA,          0, 0, 1, PA,           0, 0,            1, TA,           1, 1, TA, 1, 32'h0040_0018));
    vecs.push_back(mk("nt2_A",    1, PA,          0, 0, 1, PA,           0, 0,            0, 0,            1, 0, 0,  0, 0));
    vecs.push_back(mk("nt3_A",    1, PA,          0, 0, 1, PA,           0, 0,            0, 0,            1, 0, 0,  0, 0));
    vecs.push_back(mk("tk_A01",   0, 0,           0, 0, 1, PA,           1, TA,           0, 0,            0, 0, 0,  1, TA));
    vecs.push_back(mk("sat_chk",  1, PA,          0, 0, 0, 0,            0, 0,            0, 0,            1, 0, 0,  0, 0));
    vecs.push_back(mk("tgt_mis",  0, 0,           0, 0, 1, PA,           1, TA,           1, 32'h0040_0200, 0, 0, 0,  1, TA));
    vecs.push_back(mk("tk_ok",    1, PA,          0, 0, 1, PA,           1, TA,           1, TA,           1, 1, TA, 0, 0));
    vecs.push_back(mk("rbw_C",    1, PC,          0, 0, 1, PC,           1, TC,           0, 0,            1, 0, 0,  1, TC));
    vecs.push_back(mk("hit_C",    1, PC,          0, 0, 0, 0,            0, 0,            0, 0,            1, 1, TC, 0, 0));
    vecs.push_back(mk("wrap",     0, 0,           0, 0, 1, 32'hFFFF_FFFC, 0, 0,           1, 0,            0, 0, 0,  1, 32'h0000_0004));
    vecs.push_back(mk("miss_nt",  0, 0,           0, 0, 1, PB,           0, 0,            0, 0,            0, 0, 0,  0, 0));
    vecs.push_back(mk("keep_A",   1, PA,          0, 0, 0, 0,            0, 0,            0, 0,            1, 1, TA, 0, 0));
    vecs.push_back(mk("stall1",   1, PC,          1, 0, 1, PA,           0, 0,            1, TA,           1, 1, TA, 1, 32'h0040_0018));
    vecs.push_back(mk("stall2",   0, 0,           1, 0, 0, 0,            0, 0,            0, 0,            1, 1, TA, 0, 0));
    vecs.push_back(mk("stall3",   1, PC,          1, 0, 0, 0,            0, 0,            0, 0,            1, 1, TA, 0, 0));
    vecs.push_back(mk("post_stl", 1, PA,          0, 0, 0, 0,            0, 0,            0, 0,            1, 1, TA, 0, 0));
    vecs.push_back(mk("flush",    1, PC,          0, 1, 1, PD,           1, 32'h0040_0400, 0, 0,           1, 1, TC, 1, 32'h0040_0400));
    vecs.push_back(mk("flushd_C", 1, PC,          0, 0, 0, 0,            0, 0,            0, 0,            1, 0, 0,  0, 0));
    vecs.push_back(mk("drop_D",   1, PD,          0, 0, 0, 0,            0, 0,            0, 0,            1, 0, 0,  0, 0));
    vecs.push_back(mk("flushd_A", 1, PA,          0, 0, 0, 0,            0, 0,            0, 0,            1, 0, 0,  0, 0));

    idle_inputs();
    resetn = 0;
    #3;
    check_outs("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      lookup_valid = vecs[i].lk_vld; lookup_pc = vecs[i].lk_pc;
      stall = vecs[i].stl; flush_table = vecs[i].flush;
      upd_valid = vecs[i].u_vld; upd_pc = vecs[i].u_pc; upd_taken = vecs[i].u_tk;
      upd_target = vecs[i].u_tgt; upd_pred_taken = vecs[i].u_ptk;
      upd_pred_target = vecs[i].u_ptgt;
      @(posedge clk);
      #1;
      check_outs(vecs[i].name, vecs[i].e_pv, vecs[i].e_pt, vecs[i].e_ptgt,
                 vecs[i].e_mis, vecs[i].e_red);
    end

    // Repopulate C, then reset mid-operation: outputs clear at once, table comes back empty.
    @(negedge clk);
    idle_inputs();
    upd_valid = 1; upd_pc = PC; upd_taken = 1; upd_target = TC;
    @(posedge clk); #1;
    check_outs("realloc_C", 0, 0, 0, 1, TC);
    @(negedge clk);
    idle_inputs();
    lookup_valid = 1; lookup_pc = PC;
    upd_valid = 1; upd_pc = PA; upd_taken = 1; upd_target = TA;
    @(posedge clk); #1;
    check_outs("rehit_C", 1, 1, TC, 1, TA);
    #2;
    resetn = 0;
    #1;
    check_outs("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1;
    idle_inputs();
    lookup_valid = 1; lookup_pc = PC;
    @(posedge clk); #1;
    check_outs("post_rst", 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
